unstripe_sched: RTL and testbench

Lane scheduler and skew buffer for the PHY receive path. It accepts 32-bit words from the two receive lanes and absorbs small inter-lane skew in per-lane FIFOs. It re-serialises the words onto one output in strict lane-0/lane-1 alternation. A small state machine acquires the first lane-0 word, drops stray lane-1 words, and recovers from idle timeouts and FIFO overflow.

---
 rtl/unstripe_sched.sv | 175 +++++++++++++++++
 tb/tb_unstripe_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/unstripe_sched.sv
// Two-lane receive unstriper: per-lane skew FIFOs drained in strict lane-0/lane-1
// alternation, with lane-0 acquisition, idle timeout and overflow recovery.
module unstripe_sched #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IDLE_TO = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] lane_0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane_1,
  input  logic              valid_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              err_overflow,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic              sel, sel_nxt;
  logic [7:0]        idle_cnt, idle_cnt_nxt;
  logic [PW-1:0]     wp0, rp0, wp1, rp1;
  logic [PW-1:0]     wp0_nxt, rp0_nxt, wp1_nxt, rp1_nxt;
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              push0, push1, pop0, pop1;
  logic              ovf0, ovf1, flush;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              err_nxt;

  logic              empty0, empty1, full0, full1;
  logic [DATA_W-1:0] head0, head1;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);
  // Full: pointers differ only in the wrap bit
  assign full0  = (wp0[AW] != rp0[AW]) && (wp0[AW-1:0] == rp0[AW-1:0]);
  assign full1  = (wp1[AW] != rp1[AW]) && (wp1[AW-1:0] == rp1[AW-1:0]);
  assign head0  = mem0[rp0[AW-1:0]];
  assign head1  = mem1[rp1[AW-1:0]];

  // Next-state, FIFO control and output next values
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    idle_cnt_nxt = idle_cnt;
    push0        = 1'b0;
    push1        = 1'b0;
    pop0         = 1'b0;
    pop1         = 1'b0;
    ovf0         = 1'b0;
    ovf1         = 1'b0;
    flush        = 1'b0;
    drop_inc     = 2'd0;
    data_nxt     = '0;
    valid_nxt    = 1'b0;
    err_nxt      = err_overflow;

    case (state)
      IDLE: begin
        if (valid_0) begin
          push0     = 1'b1;
          push1     = valid_1;
          state_nxt = RUN;
        end else if (valid_1) begin
          drop_inc = 2'd1;
        end
      end
      RUN: begin
        pop0 = !sel && !empty0;
        pop1 = sel && !empty1;
        ovf0 = valid_0 && full0 && !pop0;
        ovf1 = valid_1 && full1 && !pop1;
        if (ovf0 || ovf1) begin
          // Overflow loses alignment: flush both lanes and reacquire
          flush        = 1'b1;
          pop0         = 1'b0;
          pop1         = 1'b0;
          state_nxt    = IDLE;
          sel_nxt      = 1'b0;
          idle_cnt_nxt = 8'd0;
          err_nxt      = 1'b1;
          drop_inc     = {1'b0, ovf0} + {1'b0, ovf1};
        end else begin
          push0 = valid_0;
          push1 = valid_1;
          if (pop0) begin
            data_nxt  = head0;
            valid_nxt = 1'b1;
            sel_nxt   = 1'b1;
          end else if (pop1) begin
            data_nxt  = head1;
            valid_nxt = 1'b1;
            sel_nxt   = 1'b0;
          end
          if (!valid_0 && !valid_1 && empty0 && empty1) begin
            if (idle_cnt == 8'(IDLE_TO - 1)) begin
              state_nxt    = IDLE;
              sel_nxt      = 1'b0;
              idle_cnt_nxt = 8'd0;
            end else begin
              idle_cnt_nxt = idle_cnt + 8'd1;
            end
          end else begin
            idle_cnt_nxt = 8'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (flush) begin
      wp0_nxt = '0;
      rp0_nxt = '0;
      wp1_nxt = '0;
      rp1_nxt = '0;
    end else begin
      wp0_nxt = wp0 + PW'(push0);
      rp0_nxt = rp0 + PW'(pop0);
      wp1_nxt = wp1 + PW'(push1);
      rp1_nxt = rp1 + PW'(pop1);
    end

    drop_sum = 9'(drop_cnt) + 9'(drop_inc);
  end

  // State and output registers
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state        <= IDLE;
      sel          <= 1'b0;
      idle_cnt     <= 8'd0;
      wp0          <= '0;
      rp0          <= '0;
      wp1          <= '0;
      rp1          <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      active       <= 1'b0;
      err_overflow <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      idle_cnt     <= idle_cnt_nxt;
      wp0          <= wp0_nxt;
      rp0          <= rp0_nxt;
      wp1          <= wp1_nxt;
      rp1          <= rp1_nxt;
      data_out     <= data_nxt;
      valid_out    <= valid_nxt;
      active       <= (state_nxt == RUN);
      err_overflow <= err_nxt;
      drop_cnt     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Lane storage; contents are don't-care while pointers say empty
  always_ff @(posedge clk_2f) begin
    if (push0) mem0[wp0[AW-1:0]] <= lane_0;
    if (push1) mem1[wp1[AW-1:0]] <= lane_1;
  end

endmodule

// File: tb/tb_unstripe_sched.sv
// Directed bench for unstripe_sched: alignment, stray drops, skew, overflow,
// idle timeout, drop saturation and asynchronous reset.
module tb_unstripe_sched;

  logic        clk_2f = 1'b0;
  logic        reset_L;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1;
  logic [31:0] data_out;
  logic        valid_out, active, err_overflow;
  logic [7:0]  drop_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got[$];
  bit          seen_dead;

  unstripe_sched #(.DATA_W(32), .DEPTH(4), .IDLE_TO(8)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L),
    .lane_0(lane_0), .valid_0(valid_0),
    .lane_1(lane_1), .valid_1(valid_1),
    .data_out(data_out), .valid_out(valid_out), .active(active),
    .err_overflow(err_overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  always @(negedge clk_2f) begin
    if (valid_out) begin
      got.push_back(data_out);
      if (data_out == 32'hDEAD0001) seen_dead = 1'b1;
    end
  end

  task automatic drive(input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1);
    valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f);
    reset_L = 1'b1;
    got.delete();
    seen_dead = 1'b0;
  endtask

  task automatic test_reset();
    valid_0 = 1'b1; valid_1 = 1'b1; lane_0 = 32'h1; lane_1 = 32'h2;
    reset_L = 1'b0;
    #12;
    n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    n_tests++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_overflow); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    apply_reset();
  endtask

  task automatic test_aligned();
    apply_reset();
    drive(1'b1, 32'hA0, 1'b1, 32'hB0);
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL aligned_first_valid: got %b want 0", valid_out); end
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL aligned_active: got %b want 1", active); end
    drive(1'b1, 32'hA1, 1'b1, 32'hB1);
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'hA0) begin n_fail++; $display("FAIL aligned_w0: got %b/%h want 1/000000a0", valid_out, data_out); end
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'hB0) begin n_fail++; $display("FAIL aligned_w1: got %b/%h want 1/000000b0", valid_out, data_out); end
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'hA1) begin n_fail++; $display("FAIL aligned_w2: got %b/%h want 1/000000a1", valid_out, data_out); end
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'hB1) begin n_fail++; $display("FAIL aligned_w3: got %b/%h want 1/000000b1", valid_out, data_out); end
    idle();
    n_tests++; if (valid_out !== 1'b0 || data_out !== 32'h0) begin n_fail++; $display("FAIL aligned_drain: got %b/%h want 0/00000000", valid_out, data_out); end
  endtask

  task automatic test_stray();
    apply_reset();
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD0001);
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL stray_drop: got %0d want 1", drop_cnt); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL stray_active: got %b want 0", active); end
    drive(1'b1, 32'h11, 1'b1, 32'h22);
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'h11) begin n_fail++; $display("FAIL stray_w0: got %b/%h want 1/00000011", valid_out, data_out); end
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'h22) begin n_fail++; $display("FAIL stray_w1: got %b/%h want 1/00000022", valid_out, data_out); end
    repeat (3) idle();
    n_tests++; if (seen_dead !== 1'b0 || got.size() != 2) begin n_fail++; $display("FAIL stray_never_out: got seen=%b count=%0d want seen=0 count=2", seen_dead, got.size()); end
  endtask

  task automatic test_skew();
    int bad;
    apply_reset();
    // Each lane supplies every other cycle; lane 1 trails lane 0 by 3 cycles
    for (int c = 0; c < 24; c++) begin
      logic        v0, v1;
      logic [31:0] d0, d1;
      v0 = (c < 16) && (c % 2 == 0);
      d0 = 32'hA000_0000 | 32'(c / 2);
      v1 = (c >= 3) && (c <= 17) && (c % 2 == 1);
      d1 = 32'hB000_0000 | 32'((c - 3) / 2);
      drive(v0, v0 ? d0 : 32'h0, v1, v1 ? d1 : 32'h0);
    end
    n_tests++; if (got.size() != 16) begin n_fail++; $display("FAIL skew_count: got %0d want 16", got.size()); end
    bad = -1;
    for (int k = 0; k < 8; k++) begin
      if (bad < 0 && 2 * k + 1 < got.size()) begin
        if (got[2*k] !== (32'hA000_0000 | 32'(k))) bad = 2 * k;
        else if (got[2*k+1] !== (32'hB000_0000 | 32'(k))) bad = 2 * k + 1;
      end
    end
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL skew_order: word %0d got %h want lane%0d index %0d", bad, got[bad], bad % 2, bad / 2); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL skew_drop: got %0d want 0", drop_cnt); end
    n_tests++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL skew_err: got %b want 0", err_overflow); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hC000_0000 | 32'(i), 1'b0, 32'h0);
      if (i == 1) begin
        n_tests++; if (valid_out !== 1'b1 || data_out !== 32'hC000_0000) begin n_fail++; $display("FAIL ovf_first: got %b/%h want 1/c0000000", valid_out, data_out); end
      end
      if (i == 4) begin
        n_tests++; if (err_overflow !== 1'b0 || active !== 1'b1) begin n_fail++; $display("FAIL ovf_prefull: got err=%b act=%b want err=0 act=1", err_overflow, active); end
      end
    end
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err_overflow); end
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL ovf_active: got %b want 0", active); end
    drive(1'b1, 32'h55, 1'b1, 32'h66);
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'h55) begin n_fail++; $display("FAIL ovf_flushed0: got %b/%h want 1/00000055", valid_out, data_out); end
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'h66) begin n_fail++; $display("FAIL ovf_flushed1: got %b/%h want 1/00000066", valid_out, data_out); end
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(1'b1, 32'hE0, 1'b1, 32'hE1);
    idle();
    idle();
    repeat (7) idle();
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got %b want 1", active); end
    idle();
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL timeout_fire: got %b want 0", active); end
    drive(1'b0, 32'h0, 1'b1, 32'hE2);
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_stray: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_async_reset_sat();
    apply_reset();
    repeat (300) drive(1'b0, 32'h0, 1'b1, 32'hDEAD0002);
    n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
    drive(1'b1, 32'h77, 1'b1, 32'h88);
    idle();
    n_tests++; if (valid_out !== 1'b1 || data_out !== 32'h77) begin n_fail++; $display("FAIL sat_stream: got %b/%h want 1/00000077", valid_out, data_out); end
    #3;
    reset_L = 1'b0;
    #1;
    n_tests++; if (data_out !== 32'h0 || valid_out !== 1'b0 || active !== 1'b0 || err_overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got d=%h v=%b a=%b e=%b c=%0d want all 0", data_out, valid_out, active, err_overflow, drop_cnt);
    end
    @(negedge clk_2f);
    reset_L = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD0003);
    n_tests++; if (drop_cnt !== 8'd1 || active !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got c=%0d a=%b want c=1 a=0", drop_cnt, active); end
  endtask

  initial begin
    reset_L = 1'b0;
    valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    seen_dead = 1'b0;
    test_reset();
    test_aligned();
    test_stray();
    test_skew();
    test_overflow();
    test_timeout();
    test_async_reset_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
